// File: rtl/code_ser_pkg.sv
// Shared types and helpers for the code word serializer.
package code_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int PAR_MAX_W = 1024;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Zero-extension does not change the XOR reduction, so any narrower word can be passed in.
  function automatic logic odd_par(input logic [PAR_MAX_W-1:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/code_serializer.sv
// Serializes a parallel code word MSB-first onto A, one bit per clock, with optional idle gap.
// Define CODE_SER_PARITY_EN to append an odd-parity bit to every frame.
module code_serializer
  import code_ser_pkg::*;
#(
  parameter int   WIDTH      = 16,
  parameter logic IDLE_BIT   = 1'b0,
  parameter int   GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             A,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = cnt_width(WIDTH);
`ifdef CODE_SER_PARITY_EN
  localparam int FRAME_W = WIDTH + 1;
`else
  localparam int FRAME_W = WIDTH;
`endif
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_W - 1);
  localparam logic [7:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t               r_state;
  logic [FRAME_W-1:0]   r_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic [7:0]           r_gap;
  logic                 r_a;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [FRAME_W-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [7:0]           w_gap_nxt;
  logic                 w_a_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_accept;
  logic                 w_last_bit;

`ifdef CODE_SER_PARITY_EN
  assign w_frame = {data_i, odd_par(PAR_MAX_W'(data_i))};
`else
  assign w_frame = data_i;
`endif

  assign w_last_bit = (r_state == SHIFT) && (r_cnt == '0);
  // Without a gap the final-bit cycle may accept the next word so frames abut.
  assign ready_o    = (r_state == IDLE) || ((GAP_CYCLES == 0) && w_last_bit);
  assign w_accept   = valid_i && ready_o;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_a_nxt     = IDLE_BIT;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: ;
      SHIFT: begin
        if (r_cnt != '0) begin
          w_a_nxt     = r_shift[FRAME_W-1];
          w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_done_nxt  = (r_cnt == CNT_W'(1));
          w_busy_nxt  = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          w_state_nxt = GAP;
          w_gap_nxt   = GAP_LOAD;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GAP: begin
        if (r_gap == 8'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt  = r_gap - 8'd1;
          w_busy_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Acceptance overrides whatever the current state decided.
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_a_nxt     = w_frame[FRAME_W-1];
      w_shift_nxt = {w_frame[FRAME_W-2:0], 1'b0};
      w_cnt_nxt   = CNT_LOAD;
      w_busy_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= 8'd0;
      r_a     <= IDLE_BIT;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_a     <= w_a_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign A      = r_a;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_code_serializer.sv
// Bench for code_serializer: a gap-free and a 3-cycle-gap instance checked every cycle
// against a frame-timeline model (frame start/end cycle and word per instance).
module tb_code_serializer;

  localparam int W = 16;
  localparam int GAP1 = 3;
`ifdef CODE_SER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  localparam int NEVER = 1 << 30;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data  [2];
  logic         valid [2];
  logic         ready [2];
  logic         a     [2];
  logic         busy  [2];
  logic         done  [2];

  code_serializer #(.WIDTH(W), .IDLE_BIT(1'b0), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .data_i(data[0]), .valid_i(valid[0]),
    .ready_o(ready[0]), .A(a[0]), .busy_o(busy[0]), .done_o(done[0]));

  code_serializer #(.WIDTH(W), .IDLE_BIT(1'b0), .GAP_CYCLES(GAP1)) dut1 (
    .clk(clk), .reset(reset), .data_i(data[1]), .valid_i(valid[1]),
    .ready_o(ready[1]), .A(a[1]), .busy_o(busy[1]), .done_o(done[1]));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: frame of instance i occupies cycles st[i]..en[i], followed by its gap.
  int           st [2];
  int           en [2];
  logic [W-1:0] wd [2];
  logic [W-1:0] pend0 [$];
  logic [W-1:0] pend1 [$];
  logic [W-1:0] cap0;
  bit           cap_on;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] word, input int k);
    if (k < W) return word[W-1-k];
    return ~^word;
  endfunction

  task automatic push(input logic [W-1:0] w);
    pend0.push_back(w);
    pend1.push_back(w);
  endtask

  task automatic step(input bit rst5, input bit rnd);
    logic er [2];
    bit   do_rst;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int   gap;
      bit   in_f, in_g;
      logic ea;
      string s;
      gap  = (i == 0) ? 0 : GAP1;
      in_f = (cyc >= st[i]) && (cyc <= en[i]);
      in_g = !in_f && (cyc > en[i]) && (cyc <= en[i] + gap);
      ea   = in_f ? exp_bit(wd[i], cyc - st[i]) : 1'b0;
      er[i] = (!in_f && !in_g) || (gap == 0 && in_f && cyc == en[i]);
      s = (i == 0) ? "g0" : "g3";
      chk({"A_", s},     32'(a[i]),     32'(ea));
      chk({"busy_", s},  32'(busy[i]),  32'(in_f || in_g));
      chk({"done_", s},  32'(done[i]),  32'(in_f && cyc == en[i]));
      chk({"ready_", s}, 32'(ready[i]), 32'(er[i]));
      if (i == 0 && cap_on && in_f && (cyc - st[0]) < W) cap0[W-1-(cyc-st[0])] = a[0];
    end
    do_rst = (rst5 && (cyc - st[0]) == 4) || (rnd && $urandom_range(63) == 0);
    reset = do_rst;
    for (int i = 0; i < 2; i++) begin
      bit           have;
      logic [W-1:0] front;
      have  = (i == 0) ? (pend0.size() > 0) : (pend1.size() > 0);
      front = '0;
      if (have) front = (i == 0) ? pend0[0] : pend1[0];
      if (er[i] && have && (!rnd || $urandom_range(3) != 0)) begin
        valid[i] = 1'b1;
        data[i]  = front;
      end else if (!er[i] && rnd) begin
        valid[i] = 1'($urandom);
        data[i]  = W'($urandom);
      end else begin
        valid[i] = 1'b0;
        data[i]  = W'($urandom);
      end
      if (do_rst) begin
        st[i] = NEVER;
        en[i] = -1000;
      end else if (valid[i] && er[i]) begin
        st[i] = cyc + 1;
        en[i] = cyc + FL;
        wd[i] = data[i];
        if (i == 0) void'(pend0.pop_front());
        else        void'(pend1.pop_front());
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
      st[i]    = NEVER;
      en[i]    = -1000;
      wd[i]    = '0;
    end
    cap0   = '0;
    cap_on = 1'b0;
    repeat (2) @(posedge clk);

    cap_on = 1'b1;
    push(16'hA4D3);
    for (int n = 0; n < 25; n++) step(1'b0, 1'b0);
    cap_on = 1'b0;
    chk("a4d3_stream", 32'(cap0), 32'h0000A4D3);

    push(16'hFFFF);
    push(16'h0000);
    for (int n = 0; n < 45; n++) step(1'b0, 1'b0);

    push(16'h1234);
    for (int n = 0; n < 25; n++) step(1'b1, 1'b0);
    pend0.delete();
    pend1.delete();
    push(16'hBEEF);
    for (int n = 0; n < 25; n++) step(1'b0, 1'b0);

    push(16'h0001);
    push(16'h0003);
    for (int n = 0; n < 50; n++) step(1'b0, 1'b0);

    for (int n = 0; n < 800; n++) begin
      if (pend0.size() == 0 && $urandom_range(3) == 0) pend0.push_back(W'($urandom));
      if (pend1.size() == 0 && $urandom_range(3) == 0) pend1.push_back(W'($urandom));
      step(1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_serializer.md
Name: code_serializer

Overview:
- Upstream feeder for the fsm_moore pattern detector.
- Accepts a parallel code word over a valid/ready handshake and shifts it out MSB-first, one bit per clock, on the serial line A.
- Allows whole code words (e.g. 16'b1010010011010011, which contains two 01001 sequences) to be driven into the detector without bit-level stimulus.

Parameters:
- WIDTH, 16, code word width in bits (>= 2).
- IDLE_BIT, 1'b0, value driven on A when no frame is in progress.
- GAP_CYCLES, 0, number of idle cycles inserted after each frame before the next word is accepted (0..255).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- data_i  input  WIDTH  parallel code word; bit WIDTH-1 is transmitted first.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  serializer can accept a word this cycle.
- A  output  1  serial bit stream; connects directly to fsm_moore.A.
- busy_o  output  1  a frame or gap is in progress.
- done_o  output  1  one-cycle pulse, high while the last bit of a frame is on A.

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: A=IDLE_BIT, ready_o=1, busy_o=0, done_o=0, state=IDLE, bit counter=0. Reset mid-frame aborts the frame immediately; the remaining bits are never sent.
- FSM states: IDLE, SHIFT, GAP.
- Acceptance: a word is accepted on a rising edge where valid_i && ready_o; data_i is sampled on that edge only.
- IDLE:
  - ready_o=1, A=IDLE_BIT.
  - On acceptance: load the shift register, counter=WIDTH-1, go to SHIFT.
  - A shows data_i[WIDTH-1] from the cycle after acceptance (latency 1 clock). All outputs are registered except ready_o.
- SHIFT:
  - Each cycle A = current MSB of the shift register.
  - The register shifts left by 1 and the counter decrements every edge.
  - Each bit is held for exactly one clock.
  - done_o=1 in the cycle the final bit is on A.
  - After the final bit: if GAP_CYCLES>0 go to GAP, else go to IDLE.
- Back-to-back (GAP_CYCLES=0 only):
  - ready_o is also high during the final-bit cycle.
  - A word accepted then starts on the next cycle with no idle bit between frames.
- GAP:
  - A=IDLE_BIT and ready_o=0 for exactly GAP_CYCLES cycles, then go to IDLE.
- busy_o: 1 in SHIFT and GAP.
- ready_o: 0 in SHIFT (except the back-to-back case above) and in GAP.
- valid_i while not ready_o is ignored; data_i is not required to be held.
- Counter width is $clog2(WIDTH+1). The counter never underflows; it is reloaded only on acceptance.

Optional Feature:
- Macro: CODE_SER_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing bit equal to odd parity over the WIDTH data bits (~^data), so the frame is WIDTH+1 bits.
  - done_o accompanies the parity bit.
  - Back-to-back ready_o applies on the parity-bit cycle.
- Undefined: frames are exactly WIDTH bits, with no parity logic or state.

Decomposition:
- Shared package code_ser_pkg holds:
  - the state enum typedef (IDLE, SHIFT, GAP);
  - the odd-parity function;
  - the localparam CNT_W computation helper.
- No sub-module is warranted: single module code_serializer; the gap counter and bit counter are inline.

Test Plan:
- Reset held for 2 cycles, then data_i=16'hA4D3 with valid_i for 1 cycle -> A = 1,0,1,0,0,1,0,0,1,1,0,1,0,0,1,1 over 16 consecutive cycles starting 1 cycle after acceptance; done_o high only on cycle 16. With fsm_moore attached, unlock pulses after both 01001 occurrences.
- GAP_CYCLES=0, two words 16'hFFFF then 16'h0000 offered continuously -> 32 contiguous bits (16 ones then 16 zeros) with no idle bit; ready_o high on acceptance cycle and on bit-16 cycle only.
- GAP_CYCLES=3 -> after the last bit, A=IDLE_BIT and ready_o=0 for exactly 3 cycles; ready_o rises on the 4th cycle.
- reset asserted on the 5th bit of a frame -> next cycle A=IDLE_BIT, ready_o=1, busy_o=0, done_o never pulses; a fresh word then serializes correctly.
- valid_i toggled mid-frame with different data -> ignored; the transmitted stream is unchanged.
- CODE_SER_PARITY_EN defined, data 16'h0001 -> 17 bits, last bit 0; data 16'h0003 -> last bit 1; done_o on bit 17.
